cla_add_sched: RTL and testbench
================================

// Module: cla_add_sched
// PURPOSE
//   Round-robin scheduler sharing one bit16cla instance (registered 17-bit sum, 1-cycle latency) among NREQ requesters.
//   Issues one 16-bit add per cycle; sequences 32-bit adds as low/high passes with the carry chained through the adder.
//   Broadcasts tagged results on a shared response bus; sits between the fp16 datapath clients and the mantissa adder.
// PARAMETERS
//   NREQ  4  number of requesters (2..8)
//   IDW   2  width of requester id, = clog2(NREQ)
// PORTS
//   clk       in   1         clock, all state on posedge
//   rst       in   1         synchronous, active-high reset
//   req       in   NREQ      per-requester request level; held with operands until granted
//   wide      in   NREQ      per-requester: 1 = 32-bit add, 0 = 16-bit add
//   a_in      in   NREQ*32   operand A, requester i at [32i+31:32i]; narrow uses [15:0] only
//   b_in      in   NREQ*32   operand B, same packing
//   gnt       out  NREQ      one-hot grant, combinational, ARB state only
//   add_a     out  16        to bit16cla a
//   add_b     out  16        to bit16cla b
//   add_cin   out  1         to bit16cla cin
//   add_s     in   17        from bit16cla s (registered inside adder)
//   rsp_valid out  1         response valid, one-cycle pulse per request
//   rsp_id    out  IDW       requester index of response
//   rsp_wide  out  1         response belongs to a 32-bit request
//   rsp_sum   out  33        narrow: {16'b0, add_s}; wide: {add_s, lo_q[15:0]}
// BEHAVIOUR
//   - Reset: state=ARB, ptr=0, op_vld/s_vld=0, op regs=0, lo_q=0 -> gnt=0, rsp_valid=0, rsp_id=0, rsp_wide=0,
//     rsp_sum=0, add_a/add_b=0, add_cin=0. Adder register is not reset; its output is ignored while s_vld=0.
//   - FSM: ARB -> (narrow win) ARB; ARB -> (wide win) LO_WAIT -> HI -> ARB. No grants in LO_WAIT or HI.
//   - ARB: winner = first i with req[i] searching ptr, ptr+1, ... mod NREQ; gnt[winner]=1 same cycle.
//     On grant edge: op_a/op_b <= a_in/b_in[15:0] of winner, op_id <= winner, op_vld <= 1, ptr <= (winner+1)%NREQ.
//     Wide win: also hold hi_a/hi_b <= [31:16], op_wide <= 1. No req: op_vld <= 0, ptr unchanged.
//   - Requester drops or changes req the cycle after its gnt; req held while gnt=0 is never lost.
//   - add_a=op_a, add_b=op_b; add_cin=0 except in HI where add_cin=add_s[16] (carry of low pass).
//   - Pipeline: s_vld/s_id/s_wide <= op_vld/op_id/op_wide each edge (aligned with adder register).
//   - Narrow latency: granted cycle t -> rsp_valid at t+2, rsp_sum={16'b0,add_s}.
//   - LO_WAIT: adder sees low halves; on exit edge op <= hi halves, op_vld=1 (flagged hi). Low-pass s_vld is
//     suppressed (no response for low pass).
//   - HI: adder sees hi halves + carry; on exit edge lo_q <= add_s[15:0].
//   - Wide latency: granted t -> rsp_valid at t+3, rsp_sum={add_s[16:0], lo_q[15:0]}, rsp_wide=1.
//   - Throughput: 1 narrow/cycle; wide costs 3 issue slots. An in-flight narrow never corrupts the wide carry
//     (its sum is on add_s one cycle before LO_WAIT ends).
//   - Arithmetic: unsigned, no saturation; bit 32 (wide) / bit 16 (narrow) is carry-out.
//   - rst asserted mid-operation: all in-flight ops dropped, no rsp_valid after reset edge, FSM returns to ARB.
//   - req for index >= NREQ does not exist; ptr wraps NREQ-1 -> 0.
// TESTING
//   1 req0 narrow a=16'h1234 b=16'h0FF0, gnt0 at t -> rsp_valid t+2, id=0, rsp_sum=33'h0_0000_2224, wide=0.
//   2 req2 wide a=32'h0000_FFFF b=32'h0000_0001 -> gnt2 at t, rsp at t+3, rsp_sum=33'h0_0001_0000, wide=1.
//   3 req3 wide a=32'hFFFF_FFFF b=32'h0000_0001 -> rsp at t+3, rsp_sum=33'h1_0000_0000 (carry out).
//   4 req[3:0]=4'hF held, all narrow, ptr=0 -> gnt 0,1,2,3,0 on consecutive cycles; rsp_id same order 2 cycles later.
//   5 ptr=1, req1 wide + req2 narrow at t -> gnt1 at t, gnt=0 at t+1,t+2, gnt2 at t+3; rsp id1 t+3, id2 t+5.
//   6 wide grant at t, rst high at t+1 -> no rsp_valid t+2..t+4, ptr=0, next req0 granted first cycle after rst low.

Source files
------------

// File: rtl/cla_add_sched_if.sv
// Request/response and adder bus of the shared-adder scheduler.
// The master side is the client/adder environment; the slave side is the scheduler.
interface cla_add_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    wide;
    logic [NREQ*32-1:0] a_in;
    logic [NREQ*32-1:0] b_in;
    logic [NREQ-1:0]    gnt;
    logic [15:0]        add_a;
    logic [15:0]        add_b;
    logic               add_cin;
    logic [16:0]        add_s;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_wide;
    logic [32:0]        rsp_sum;

    modport master (
        output req, wide, a_in, b_in, add_s,
        input  gnt, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_wide, rsp_sum
    );

    modport slave (
        input  req, wide, a_in, b_in, add_s,
        output gnt, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_wide, rsp_sum
    );
endinterface

// File: rtl/cla_add_sched.sv
// Round-robin scheduler sharing one registered 16-bit CLA among NREQ requesters;
// 32-bit adds run as a low pass then a high pass with the carry fed back through add_cin.
module cla_add_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    cla_add_sched_if.slave bus
);

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        LO_WAIT = 2'd1,
        HI      = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win;
    logic            any_req;
    logic [31:0]     a_arr [NREQ];
    logic [31:0]     b_arr [NREQ];

    logic [15:0]     op_a_p0;
    logic [15:0]     op_b_p0;
    logic [15:0]     hi_a_p0;
    logic [15:0]     hi_b_p0;
    logic [IDW-1:0]  op_id_p0;
    logic            vld_p0;
    logic            wide_p0;
    logic            hi_p0;

    logic            vld_p1;
    logic            wide_p1;
    logic [IDW-1:0]  id_p1;
    logic [15:0]     lo_q;

    function automatic logic [IDW-1:0] wrap_idx(input int v);
        int m;
        m = v % NREQ;
        return m[IDW-1:0];
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = bus.a_in[32*i +: 32];
        assign b_arr[i] = bus.b_in[32*i +: 32];
    end

    // Descending scan so the candidate closest to ptr is the last one written.
    always_comb begin
        any_req = 1'b0;
        win     = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[wrap_idx(int'(ptr) + k)]) begin
                any_req = 1'b1;
                win     = wrap_idx(int'(ptr) + k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (any_req && bus.wide[win]) state_nxt = LO_WAIT;
            LO_WAIT: state_nxt = HI;
            HI:      state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        bus.gnt     = '0;
        bus.add_cin = 1'b0;
        if (state == ARB && any_req) begin
            bus.gnt[win] = 1'b1;
        end
        if (state == HI) begin
            bus.add_cin = bus.add_s[16];
        end
    end

    // Issue stage p0: operands presented to the adder
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            op_a_p0  <= '0;
            op_b_p0  <= '0;
            hi_a_p0  <= '0;
            hi_b_p0  <= '0;
            op_id_p0 <= '0;
            vld_p0   <= 1'b0;
            wide_p0  <= 1'b0;
            hi_p0    <= 1'b0;
            lo_q     <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (any_req) begin
                        op_a_p0  <= a_arr[win][15:0];
                        op_b_p0  <= b_arr[win][15:0];
                        op_id_p0 <= win;
                        vld_p0   <= 1'b1;
                        wide_p0  <= bus.wide[win];
                        hi_p0    <= 1'b0;
                        ptr      <= wrap_idx(int'(win) + 1);
                        if (bus.wide[win]) begin
                            hi_a_p0 <= a_arr[win][31:16];
                            hi_b_p0 <= b_arr[win][31:16];
                        end
                    end else begin
                        vld_p0 <= 1'b0;
                    end
                end
                LO_WAIT: begin
                    op_a_p0 <= hi_a_p0;
                    op_b_p0 <= hi_b_p0;
                    vld_p0  <= 1'b1;
                    hi_p0   <= 1'b1;
                end
                HI: begin
                    vld_p0 <= 1'b0;
                    hi_p0  <= 1'b0;
                    lo_q   <= bus.add_s[15:0];
                end
                default: begin
                    vld_p0 <= 1'b0;
                    hi_p0  <= 1'b0;
                end
            endcase
        end
    end

    // Adder stage p1: tags aligned with the adder's internal sum register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            wide_p1 <= 1'b0;
            id_p1   <= '0;
        end else begin
            vld_p1  <= vld_p0 & (~wide_p0 | hi_p0);
            wide_p1 <= wide_p0;
            id_p1   <= op_id_p0;
        end
    end

    assign bus.add_a     = op_a_p0;
    assign bus.add_b     = op_b_p0;
    assign bus.rsp_valid = vld_p1;
    assign bus.rsp_id    = vld_p1 ? id_p1 : '0;
    assign bus.rsp_wide  = vld_p1 & wide_p1;
    // The adder register is never reset, so the sum is masked until a tagged result lands.
    assign bus.rsp_sum   = !vld_p1 ? 33'd0 :
                           wide_p1 ? {bus.add_s, lo_q} : {16'd0, bus.add_s};

endmodule

// File: tb/tb_cla_add_sched.sv
// Bench for cla_add_sched: directed scenarios plus randomized traffic against a
// transaction-level round-robin/latency model, with a behavioural registered adder.
module tb_cla_add_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_add_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    cla_add_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Registered 17-bit adder standing in for bit16cla.
    always_ff @(posedge clk) begin
        bus.add_s <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};
    end

    typedef struct {
        int          due;
        int          id;
        bit          wide;
        logic [32:0] sum;
    } rsp_t;

    rsp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    int          m_busy = 0;
    int          rsp_count = 0;
    bit          rearm = 1'b0;
    int          raise_pct = 0;
    logic [31:0] a_r [NREQ];
    logic [31:0] b_r [NREQ];
    int          gnt_cyc [NREQ];
    int          rsp_cyc [NREQ];
    logic [32:0] rsp_val [NREQ];
    int          gnt_order[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.a_in[32*i +: 32] = a_r[i];
            bus.b_in[32*i +: 32] = b_r[i];
        end
    endtask

    task automatic clear_marks();
        for (int i = 0; i < NREQ; i++) begin
            gnt_cyc[i] = -100;
            rsp_cyc[i] = -100;
            rsp_val[i] = '0;
        end
    endtask

    // One clock cycle: check grant and response, advance the model, update requesters.
    task automatic step();
        int              exp_g;
        int              g_seen;
        logic [NREQ-1:0] exp_gnt;
        logic [32:0]     s;
        bit              w;
        @(negedge clk);
        exp_g = -1;
        if (m_busy == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (exp_g < 0 && bus.req[i]) exp_g = i;
            end
        end
        exp_gnt = '0;
        if (exp_g >= 0) exp_gnt[exp_g] = 1'b1;
        chk("gnt", 64'(bus.gnt), 64'(exp_gnt));

        if (bus.rsp_valid) rsp_count++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("rsp_id",    64'(bus.rsp_id),    64'(exp_q[0].id));
            chk("rsp_wide",  64'(bus.rsp_wide),  64'(exp_q[0].wide));
            chk("rsp_sum",   64'(bus.rsp_sum),   64'(exp_q[0].sum));
            rsp_cyc[exp_q[0].id] = cyc;
            rsp_val[exp_q[0].id] = bus.rsp_sum;
            void'(exp_q.pop_front());
        end else begin
            chk("rsp_idle", 64'(bus.rsp_valid), 64'd0);
        end

        g_seen = -1;
        if (rst) begin
            exp_q.delete();
            m_ptr  = 0;
            m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (exp_g >= 0) begin
            w = bus.wide[exp_g];
            if (w) s = {1'b0, a_r[exp_g]} + {1'b0, b_r[exp_g]};
            else   s = 33'(a_r[exp_g][15:0]) + 33'(b_r[exp_g][15:0]);
            exp_q.push_back('{due: cyc + (w ? 3 : 2), id: exp_g, wide: w, sum: s});
            m_ptr = (exp_g + 1) % NREQ;
            if (w) m_busy = 2;
            g_seen = exp_g;
            gnt_cyc[exp_g] = cyc;
            gnt_order.push_back(exp_g);
        end

        @(posedge clk);
        cyc++;
        #1;
        if (g_seen >= 0 && !rearm) bus.req[g_seen] = 1'b0;
        if (raise_pct > 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && int'($urandom_range(99)) < raise_pct) begin
                    bus.req[i]  = 1'b1;
                    bus.wide[i] = 1'($urandom_range(1));
                    a_r[i] = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    b_r[i] = ($urandom_range(3) == 0) ? 32'h0000_0001 : $urandom;
                end
            end
        end
        drive();
    endtask

    initial begin
        int t0;
        int rc;
        int exp4[5];
        exp4 = '{0, 1, 2, 3, 0};

        rst      = 1'b1;
        bus.req  = '0;
        bus.wide = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_r[i] = '0;
            b_r[i] = '0;
        end
        drive();
        clear_marks();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_gnt",       64'(bus.gnt),       64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        chk("rst_rsp_wide",  64'(bus.rsp_wide),  64'd0);
        chk("rst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
        chk("rst_add_a",     64'(bus.add_a),     64'd0);
        chk("rst_add_b",     64'(bus.add_b),     64'd0);
        chk("rst_add_cin",   64'(bus.add_cin),   64'd0);

        // Narrow add
        clear_marks();
        a_r[0] = 32'h0000_1234; b_r[0] = 32'h0000_0FF0;
        bus.wide[0] = 1'b0; bus.req[0] = 1'b1; drive();
        repeat (4) step();
        chk("t1_lat", 64'(rsp_cyc[0] - gnt_cyc[0]), 64'd2);
        chk("t1_sum", 64'(rsp_val[0]), 64'h0_0000_2224);

        // Wide add with carry from low half into high half
        clear_marks();
        a_r[2] = 32'h0000_FFFF; b_r[2] = 32'h0000_0001;
        bus.wide[2] = 1'b1; bus.req[2] = 1'b1; drive();
        repeat (5) step();
        chk("t2_lat", 64'(rsp_cyc[2] - gnt_cyc[2]), 64'd3);
        chk("t2_sum", 64'(rsp_val[2]), 64'h0_0001_0000);

        // Wide add with carry out of bit 31
        clear_marks();
        a_r[3] = 32'hFFFF_FFFF; b_r[3] = 32'h0000_0001;
        bus.wide[3] = 1'b1; bus.req[3] = 1'b1; drive();
        repeat (5) step();
        chk("t3_lat", 64'(rsp_cyc[3] - gnt_cyc[3]), 64'd3);
        chk("t3_sum", 64'(rsp_val[3]), 64'h1_0000_0000);

        // All requesters held, narrow, from ptr=0
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_r[i] = 32'h0000_1000 * (i + 1); b_r[i] = 32'h0000_0101 * (i + 3);
            bus.wide[i] = 1'b0; bus.req[i] = 1'b1;
        end
        drive();
        rearm = 1'b1;
        gnt_order.delete();
        repeat (5) step();
        rearm = 1'b0;
        bus.req = '0;
        for (int k = 0; k < 5; k++) chk("t4_order", 64'(gnt_order[k]), 64'(exp4[k]));
        repeat (4) step();

        // ptr=1: wide on 1 and narrow on 2 together
        clear_marks();
        a_r[1] = 32'h8000_FFFF; b_r[1] = 32'h8000_0002; bus.wide[1] = 1'b1;
        a_r[2] = 32'h0000_ABCD; b_r[2] = 32'h0000_5433; bus.wide[2] = 1'b0;
        bus.req[1] = 1'b1; bus.req[2] = 1'b1; drive();
        repeat (8) step();
        chk("t5_gnt_gap", 64'(gnt_cyc[2] - gnt_cyc[1]), 64'd3);
        chk("t5_rsp1",    64'(rsp_cyc[1] - gnt_cyc[1]), 64'd3);
        chk("t5_rsp2",    64'(rsp_cyc[2] - gnt_cyc[1]), 64'd5);

        // Reset right after a wide grant
        clear_marks();
        a_r[0] = 32'h1234_5678; b_r[0] = 32'h0FED_CBA9; bus.wide[0] = 1'b1;
        bus.req[0] = 1'b1; drive();
        t0 = cyc;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rc = rsp_count;
        step();
        bus.req[0] = 1'b1; bus.wide[0] = 1'b0;
        bus.req[3] = 1'b1; bus.wide[3] = 1'b0;
        drive();
        step();
        step();
        chk("t6_no_rsp", 64'(rsp_count - rc), 64'd0);
        chk("t6_gnt0",   64'(gnt_cyc[0] - t0), 64'd3);
        repeat (6) step();

        // Randomized traffic with occasional resets
        raise_pct = 40;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(99) == 0);
            step();
        end
        rst = 1'b0;
        raise_pct = 0;
        repeat (20) step();
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
